// File: rtl/filter_engine.sv
// filter_engine: block moving-average filter answering the filter_enable/filter_done handshake
module filter_engine #(
  parameter int DATA_W    = 8,
  parameter int WIN_LOG2  = 2,
  parameter int BLOCK_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              filter_enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] filt_out,
  output logic              filt_valid,
  output logic              filter_done
);
  localparam int TAPS = 1 << WIN_LOG2;
  localparam int SW = DATA_W + WIN_LOG2;
  localparam logic [7:0] LAST = 8'(BLOCK_LEN);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [TAPS-1:0][DATA_W-1:0] taps;
  logic [SW-1:0] sum, sum_nx;
  logic [7:0] count;
  logic accept, clear;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? (LAST == 8'd1 ? DONE : RUN) : IDLE)
             : state == RUN  ? (!filter_enable ? IDLE
                               : (accept && count + 8'd1 == LAST) ? DONE : RUN)
             : IDLE;
  end
  always_comb begin
    sample_ready = filter_enable && (state == IDLE || state == RUN);
    filter_done  = state == DONE;
  end
  // Abort and end-of-job both restart the window from zero.
  assign accept = sample_valid && sample_ready;
  assign clear  = state == DONE || (state == RUN && !filter_enable);
  assign sum_nx = sum + SW'(sample_in) - SW'(taps[TAPS-1]);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      taps       <= '0;
      sum        <= '0;
      count      <= '0;
      filt_out   <= '0;
      filt_valid <= 1'b0;
    end else begin
      filt_valid <= accept;
      if (accept) filt_out <= DATA_W'(sum_nx >> WIN_LOG2);
      if (clear) begin
        taps  <= '0;
        sum   <= '0;
        count <= '0;
      end else if (accept) begin
        taps  <= {taps[TAPS-2:0], sample_in};
        sum   <= sum_nx;
        count <= count + 8'd1;
      end
    end
endmodule
